// File: rtl/bfp_seq_ctrl.sv
// BMI / body-fat controller sharing one restoring divider across both divisions.
// Optional macro BFP_ROUND_EN: round-to-nearest instead of floor for both divisions.
module bfp_seq_ctrl #(
    parameter int DW = 22,
    parameter int OW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [7:0]    weight,
    input  logic [7:0]    height,
    input  logic [7:0]    age,
    input  logic          sex,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] bmi,
    output logic [OW-1:0] bfp,
    output logic          err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV1 = 3'd2,
        S_NUM  = 3'd3,
        S_DIV2 = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [4:0]    CNT_INIT  = 5'(DW - 1);
    localparam logic [DW-1:0] BMI_SCALE = DW'(10000);

    state_t          state_q, state_d;
    logic [7:0]      weight_q, weight_d, height_q, height_d, age_q, age_d;
    logic            sex_q, sex_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [15:0]     dvs_q, dvs_d;
    logic [15:0]     rem_q, rem_d;
    logic [4:0]      cnt_q, cnt_d;
    logic [OW-1:0]   bmi_q, bmi_d, bfp_q, bfp_d;
    logic            err_q, err_d, out_valid_q, out_valid_d, req_ready_q, req_ready_d;

    logic [16:0]     trial_s;
    logic            ge_s;
    logic [15:0]     rem_nx_s;
    logic [DW-1:0]   quot_nx_s;
    logic [DW-1:0]   mul_dvd_s;
    logic [15:0]     mul_dvs_s;
    logic [17:0]     pos_s, k_s, num_s;
    logic            num_pos_s;

    function automatic logic [OW-1:0] sat_q(input logic [DW-1:0] q);
        if (|q[DW-1:OW]) begin
            sat_q = '1;
        end else begin
            sat_q = q[OW-1:0];
        end
    endfunction

    // Shared divider step plus the MUL and NUM arithmetic feeding it
    always_comb begin
        trial_s   = {rem_q, dvd_q[DW-1]};
        ge_s      = (trial_s >= {1'b0, dvs_q});
        if (ge_s) begin
            rem_nx_s = 16'(trial_s - {1'b0, dvs_q});
        end else begin
            rem_nx_s = trial_s[15:0];
        end
        quot_nx_s = {dvd_q[DW-2:0], ge_s};
        mul_dvs_s = {8'd0, height_q} * {8'd0, height_q};
`ifdef BFP_ROUND_EN
        mul_dvd_s = DW'(weight_q) * BMI_SCALE + DW'(mul_dvs_s >> 1);
`else
        mul_dvd_s = DW'(weight_q) * BMI_SCALE;
`endif
        pos_s     = 18'(bmi_q) * 18'd120 + 18'(age_q) * 18'd23;
        k_s       = sex_q ? 18'd1620 : 18'd540;
        num_pos_s = (pos_s > k_s);
`ifdef BFP_ROUND_EN
        num_s     = pos_s - k_s + 18'd50;
`else
        num_s     = pos_s - k_s;
`endif
    end

    // Next-state and datapath load decisions
    always_comb begin
        state_d  = state_q;
        weight_d = weight_q;
        height_d = height_q;
        age_d    = age_q;
        sex_d    = sex_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        bmi_d    = bmi_q;
        bfp_d    = bfp_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    weight_d = weight;
                    height_d = height;
                    age_d    = age;
                    sex_d    = sex;
                    err_d    = 1'b0;
                    state_d  = S_MUL;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_MUL: begin
                if (height_q == 8'd0) begin
                    bmi_d   = '1;
                    bfp_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    dvd_d   = mul_dvd_s;
                    dvs_d   = mul_dvs_s;
                    rem_d   = 16'd0;
                    cnt_d   = CNT_INIT;
                    state_d = S_DIV1;
                end
            end
            S_DIV1, S_DIV2: begin
                dvd_d = quot_nx_s;
                rem_d = rem_nx_s;
                cnt_d = cnt_q - 5'd1;
                if (cnt_q != 5'd0) begin
                    state_d = state_q;
                end else if (state_q == S_DIV1) begin
                    bmi_d   = sat_q(quot_nx_s);
                    state_d = S_NUM;
                end else begin
                    bfp_d   = sat_q(quot_nx_s);
                    state_d = S_DONE;
                end
            end
            S_NUM: begin
                // Non-positive numerator divides zero so the result clamps at 0
                if (num_pos_s) begin
                    dvd_d = DW'(num_s);
                end else begin
                    dvd_d = '0;
                end
                dvs_d   = 16'd100;
                rem_d   = 16'd0;
                cnt_d   = CNT_INIT;
                state_d = S_DIV2;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        req_ready_d = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            weight_q    <= 8'd0;
            height_q    <= 8'd0;
            age_q       <= 8'd0;
            sex_q       <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= 16'd0;
            rem_q       <= 16'd0;
            cnt_q       <= 5'd0;
            bmi_q       <= '0;
            bfp_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            weight_q    <= weight_d;
            height_q    <= height_d;
            age_q       <= age_d;
            sex_q       <= sex_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            bmi_q       <= bmi_d;
            bfp_q       <= bfp_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready = req_ready_q;
    assign out_valid = out_valid_q;
    assign bmi       = bmi_q;
    assign bfp       = bfp_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bfp_seq_ctrl.sv
// Table-driven bench for bfp_seq_ctrl plus backpressure and mid-divide reset sequences.
module tb_bfp_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, sex, out_valid, out_ready, err;
    logic [7:0] weight, height, age, bmi, bfp;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [7:0] w;
        logic [7:0] h;
        logic [7:0] a;
        logic       s;
        int         bmi;
        int         bfp;
        int         err;
        int         lat;
    } vec_t;

    vec_t vecs[6];

    bfp_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .weight    (weight),
        .height    (height),
        .age       (age),
        .sex       (sex),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bmi       (bmi),
        .bfp       (bfp),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] w, input logic [7:0] h, input logic [7:0] a, input logic s);
        @(negedge clk);
        chk("req_ready_before_accept", int'(req_ready), 1);
        req_valid = 1'b1;
        weight    = w;
        height    = h;
        age       = a;
        sex       = s;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_vec(input int i);
        int lat;
        issue(vecs[i].w, vecs[i].h, vecs[i].a, vecs[i].s);
        wait_out(lat);
        chk("latency", lat, vecs[i].lat);
        chk("bmi", int'(bmi), vecs[i].bmi);
        chk("bfp", int'(bfp), vecs[i].bfp);
        chk("err", int'(err), vecs[i].err);
        @(posedge clk);
        #1;
        chk("out_valid_after_handshake", int'(out_valid), 0);
        chk("req_ready_after_handshake", int'(req_ready), 1);
    endtask

    initial begin
        int lat;
        int seen;
`ifdef BFP_ROUND_EN
        vecs[0] = '{8'd70,  8'd175, 8'd30, 1'b1, 23,  18,  0, 46};
        vecs[1] = '{8'd60,  8'd165, 8'd25, 1'b0, 22,  27,  0, 46};
`else
        vecs[0] = '{8'd70,  8'd175, 8'd30, 1'b1, 22,  17,  0, 46};
        vecs[1] = '{8'd60,  8'd165, 8'd25, 1'b0, 22,  26,  0, 46};
`endif
        vecs[2] = '{8'd40,  8'd200, 8'd18, 1'b1, 10,  0,   0, 46};
        vecs[3] = '{8'd255, 8'd50,  8'd0,  1'b1, 255, 255, 0, 46};
        vecs[4] = '{8'd100, 8'd0,   8'd40, 1'b0, 255, 0,   1, 1};
        vecs[5] = vecs[0];

        rst       = 1'b1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        weight    = 8'd0;
        height    = 8'd0;
        age       = 8'd0;
        sex       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_bmi", int'(bmi), 0);
        chk("rst_bfp", int'(bfp), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(i);
        end

        // Backpressure: hold result for 10 cycles while a new request is offered
        @(negedge clk);
        out_ready = 1'b0;
        issue(vecs[0].w, vecs[0].h, vecs[0].a, vecs[0].s);
        wait_out(lat);
        chk("bp_latency", lat, 46);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            weight    = 8'd99;
            height    = 8'd0;
            age       = 8'd77;
            sex       = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_out_valid", int'(out_valid), 1);
            chk("bp_req_ready", int'(req_ready), 0);
            chk("bp_bmi", int'(bmi), vecs[0].bmi);
            chk("bp_bfp", int'(bfp), vecs[0].bfp);
            chk("bp_err", int'(err), 0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", int'(out_valid), 0);
        chk("bp_release_req_ready", int'(req_ready), 1);
        @(posedge clk);
        #1;
        chk("bp_no_late_accept", int'(req_ready), 1);

        // Reset in the middle of the first division aborts without output
        issue(vecs[0].w, vecs[0].h, vecs[0].a, vecs[0].s);
        repeat (10) @(posedge clk);
        #1;
        chk("mid_req_ready_low", int'(req_ready), 0);
        rst = 1'b1;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_req_ready", int'(req_ready), 1);
        chk("abort_bmi", int'(bmi), 0);
        chk("abort_bfp", int'(bfp), 0);
        chk("abort_err", int'(err), 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                seen++;
            end
        end
        chk("abort_no_output", seen, 0);
        run_vec(1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bfp_seq_ctrl.md
Name: bfp_seq_ctrl

Overview:
- Sequential controller that computes BMI and then body-fat percentage (BFP) for one subject per request.
- It time-shares a single restoring divider between the BMI division and the BFP /100 division.
- Covers both sexes through a 1-bit sex input.
- Sits between the user-input front end and the display/result stage. It replaces the combinational BMI/BFP chain with a valid/ready multi-cycle unit.

Parameters:
- DW, 22, dividend width of the shared divider; also the number of iterations per division.
- OW, 8, output width of bmi and bfp; results saturate to 2^OW-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request.
- weight  input  8  weight in kg, unsigned.
- height  input  8  height in cm, unsigned.
- age  input  8  age in years, unsigned.
- sex  input  1  1 = male, 0 = female.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- bmi  output  OW  BMI, integer.
- bfp  output  OW  body-fat percent, integer.
- err  output  1  height was zero.

Behaviour:
- Reset is asynchronous and active-high. On reset: state=IDLE, req_ready=1, out_valid=0, bmi=0, bfp=0, err=0, and all datapath registers are cleared. A reset during any state aborts the operation with no output.
- States: IDLE, MUL, DIV1, NUM, DIV2, DONE.
- IDLE: req_ready=1. When req_valid is high at edge E0, register weight/height/age/sex and go to MUL. req_ready is 0 in every other state.
- MUL (one cycle):
  - If height_r==0: go to DONE with bmi=255, bfp=0, err=1.
  - Otherwise register dividend = weight_r*10000 (22 bit) and divisor = height_r*height_r (16 bit), then go to DIV1.
- DIV1: restoring division, one quotient bit per clock, exactly DW=22 cycles. An internal 5-bit counter counts from 21 down to 0.
- At DIV1 exit: bmi_r = min(quotient, 255).
- NUM (one cycle): compute signed num = 120*bmi_r + 23*age_r - K, where K=1620 for male and K=540 for female.
  - If num <= 0: load dividend 0, so the result is 0.
  - Otherwise load dividend = num and divisor = 100. Go to DIV2.
- DIV2: the same divider for 22 cycles. Result bfp = min(quotient, 255).
- DONE: out_valid=1. bmi, bfp and err stay stable until out_valid && out_ready at an edge. Then go to IDLE with out_valid=0. req_ready returns to 1 in the cycle after the output handshake.
- Latency, accept edge E0 to out_valid high:
  - Normal path: 46 edges (1 MUL + 22 DIV1 + 1 NUM + 22 DIV2).
  - Zero-height path: 1 edge.
- Throughput: one request in flight. No overlap between requests.
- The divider is shared and never idle-reset between uses. Remainder and counter are reinitialised on entry to DIV1 and to DIV2.
- err is cleared on every new accept.
- out_ready is ignored outside DONE. req_valid is ignored outside IDLE.

Optional Feature:
- BFP_ROUND_EN defined: both divisions round to nearest. In MUL, divisor>>1 is added to the dividend. In NUM, 50 is added to num when num > 0. Saturation then applies as usual.
- BFP_ROUND_EN undefined: both divisions truncate (floor). Latency is identical in both builds.

Test Plan:
- Male, w=70, h=175, age=30, out_ready=1 -> out_valid exactly 46 edges after accept. Floor build: bmi=22, bfp=17, err=0. BFP_ROUND_EN build: bmi=23, bfp=18.
- Female, w=60, h=165, age=25 -> bmi=22, bfp=26, err=0.
- Male, w=40, h=200, age=18 (num = -6) -> bmi=10, bfp=0.
- w=255, h=50, age=0, male -> bmi=255 (saturated; 1020 before clamp) and bfp=255 (289 before clamp).
- h=0 -> out_valid 1 edge after accept, bmi=255, bfp=0, err=1. The next valid request then clears err.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs stable, req_ready=0, and a new req_valid is not accepted.
  - Assert rst mid-DIV1 -> outputs return to reset values immediately and req_ready=1.
